// File: rtl/wave_display_mc.sv
// wave_display_mc
//   Multi-channel waveform renderer. Sits between the display timing
//   generator and the per-channel sample RAMs and produces one pixel per
//   clock with a fixed latency of three clocks from x/y/valid to colour.
//
// Ports
//   clk, reset_n        pixel clock, asynchronous active-low reset
//   x, y, valid         scan position and active-area flag from the timing generator
//   read_index          buffer half select, becomes the MSB of read_address
//   read_address        shared sample address to all channel RAMs (combinational)
//   read_value          per-channel samples, channel c at [c*SAMPLE_W +: SAMPLE_W],
//                       one clock after read_address
//   mode                0 = line (vertical fill between samples), 1 = dot
//   ch_enable           per-channel draw enable
//   ch_color            per-channel {r,g,b}, channel c at [c*24 +: 24]
//   valid_pixel         some trace lit this pixel
//   r, g, b             pixel colour of the lowest-index lit channel
//   ch_hit              per-channel lit flags before priority resolution
module wave_display_mc #(
  parameter int CHANNELS    = 2,
  parameter int SAMPLE_W    = 8,
  parameter int ADDR_W      = 8,
  parameter int X_START     = 256,
  parameter int X_PIX_SHIFT = 1,
  parameter int Y_TOP       = 0,
  parameter int Y_PIX_SHIFT = 1,
  parameter int V_SHIFT     = 1,
  parameter int Y_OFFSET    = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  output logic [ADDR_W:0]              read_address,
  input  logic [CHANNELS*SAMPLE_W-1:0] read_value,
  input  logic                         mode,
  input  logic [CHANNELS-1:0]          ch_enable,
  input  logic [CHANNELS*24-1:0]       ch_color,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b,
  output logic [CHANNELS-1:0]          ch_hit
);

  localparam logic signed [15:0] X_START_S = 16'(X_START);
  localparam logic signed [15:0] Y_TOP_S   = 16'(Y_TOP);
  localparam logic signed [15:0] X_SPAN_S  = 16'(1 << (ADDR_W + X_PIX_SHIFT));
  localparam logic signed [15:0] Y_SPAN_S  = 16'(1 << (SAMPLE_W + Y_PIX_SHIFT));
  localparam logic [31:0]        SAT_MAX   = 32'((1 << SAMPLE_W) - 1);

  // Scaled, offset sample clamped to the top display row instead of wrapping.
  function automatic logic [SAMPLE_W-1:0] sat_adj(input logic [SAMPLE_W-1:0] s);
    logic [31:0] sum;
    sum = 32'(s >> V_SHIFT) + 32'(Y_OFFSET);
    if (sum > SAT_MAX) return '1;
    return SAMPLE_W'(sum);
  endfunction

  // Inclusive vertical span between two consecutive samples.
  function automatic logic in_span(input logic [SAMPLE_W-1:0] p,
                                   input logic [SAMPLE_W-1:0] c,
                                   input logic [SAMPLE_W-1:0] yd);
    logic [SAMPLE_W-1:0] lo;
    logic [SAMPLE_W-1:0] hi;
    lo = (p < c) ? p : c;
    hi = (p < c) ? c : p;
    return (yd >= lo) && (yd <= hi);
  endfunction

  // ---------------- stage 0: window decode and address ----------------
  logic signed [15:0]  xo_s;
  logic signed [15:0]  yo_s;
  logic [15:0]         xo_u;
  logic [15:0]         yo_u;
  logic                in_x;
  logic                in_y;
  logic                win_p0;
  logic [ADDR_W-1:0]   col_p0;
  logic [SAMPLE_W-1:0] ydisp_p0;

  always_comb begin
    xo_s     = $signed({5'b0, x}) - X_START_S;
    yo_s     = $signed({6'b0, y}) - Y_TOP_S;
    xo_u     = xo_s;
    yo_u     = yo_s;
    in_x     = (xo_s >= 16'sd0) && (xo_s < X_SPAN_S);
    in_y     = (yo_s >= 16'sd0) && (yo_s < Y_SPAN_S);
    win_p0   = in_x && in_y && valid;
    col_p0   = ADDR_W'(xo_u >> X_PIX_SHIFT);
    ydisp_p0 = SAMPLE_W'(yo_u >> Y_PIX_SHIFT);
  end

  assign read_address = in_x ? {read_index, col_p0} : '0;

  // ---------------- stage 1: position registered, RAM data arrives ----------------
  logic                vld_p1_q,   vld_p1_d;
  logic [ADDR_W:0]     addr_p1_q,  addr_p1_d;
  logic [SAMPLE_W-1:0] ydisp_p1_q, ydisp_p1_d;
  logic [SAMPLE_W-1:0] adj_p1 [CHANNELS];

  always_comb begin
    vld_p1_d   = win_p0;
    addr_p1_d  = read_address;
    ydisp_p1_d = ydisp_p0;
  end

  // read_value lines up with the stage-1 registers, so adj belongs to stage 1.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      adj_p1[c] = sat_adj(read_value[c*SAMPLE_W +: SAMPLE_W]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q   <= 1'b0;
      addr_p1_q  <= '0;
      ydisp_p1_q <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      addr_p1_q  <= addr_p1_d;
      ydisp_p1_q <= ydisp_p1_d;
    end
  end

  // ---------------- stage 2: per-channel sample trackers ----------------
  logic                vld_p2_q,   vld_p2_d;
  logic [ADDR_W:0]     addr_p2_q,  addr_p2_d;
  logic [SAMPLE_W-1:0] ydisp_p2_q, ydisp_p2_d;
  logic                mode_p2_q,  mode_p2_d;
  logic [CHANNELS-1:0] en_p2_q,    en_p2_d;
  logic [SAMPLE_W-1:0] prev_p2_q [CHANNELS];
  logic [SAMPLE_W-1:0] prev_p2_d [CHANNELS];
  logic [SAMPLE_W-1:0] curr_p2_q [CHANNELS];
  logic [SAMPLE_W-1:0] curr_p2_d [CHANNELS];

  always_comb begin
    vld_p2_d   = vld_p1_q;
    addr_p2_d  = addr_p1_q;
    ydisp_p2_d = ydisp_p1_q;
    mode_p2_d  = mode;
    en_p2_d    = ch_enable;
    for (int c = 0; c < CHANNELS; c++) begin
      prev_p2_d[c] = prev_p2_q[c];
      curr_p2_d[c] = curr_p2_q[c];
      if (!vld_p1_q) begin
        prev_p2_d[c] = '0;
        curr_p2_d[c] = '0;
      end else if (!vld_p2_q) begin
        // Leftmost column of a row: no predecessor, so no vertical segment.
        prev_p2_d[c] = adj_p1[c];
        curr_p2_d[c] = adj_p1[c];
      end else if (addr_p1_q != addr_p2_q) begin
        prev_p2_d[c] = curr_p2_q[c];
        curr_p2_d[c] = adj_p1[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2_q   <= 1'b0;
      addr_p2_q  <= '0;
      ydisp_p2_q <= '0;
      mode_p2_q  <= 1'b0;
      en_p2_q    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        prev_p2_q[c] <= '0;
        curr_p2_q[c] <= '0;
      end
    end else begin
      vld_p2_q   <= vld_p2_d;
      addr_p2_q  <= addr_p2_d;
      ydisp_p2_q <= ydisp_p2_d;
      mode_p2_q  <= mode_p2_d;
      en_p2_q    <= en_p2_d;
      for (int c = 0; c < CHANNELS; c++) begin
        prev_p2_q[c] <= prev_p2_d[c];
        curr_p2_q[c] <= curr_p2_d[c];
      end
    end
  end

  // ---------------- stage 3: hit test and priority colour ----------------
  logic [CHANNELS-1:0] hit_p3_q, hit_p3_d;
  logic [23:0]         rgb_p3_q, rgb_p3_d;
  logic                vld_p3_q, vld_p3_d;

  always_comb begin
    hit_p3_d = '0;
    rgb_p3_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (vld_p2_q && en_p2_q[c]) begin
        if (mode_p2_q) hit_p3_d[c] = (ydisp_p2_q == curr_p2_q[c]);
        else           hit_p3_d[c] = in_span(prev_p2_q[c], curr_p2_q[c], ydisp_p2_q);
      end
    end
    // Walk from the highest index down so the lowest lit channel wins.
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (hit_p3_d[c]) rgb_p3_d = ch_color[c*24 +: 24];
    end
    vld_p3_d = |hit_p3_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_p3_q <= '0;
      rgb_p3_q <= '0;
      vld_p3_q <= 1'b0;
    end else begin
      hit_p3_q <= hit_p3_d;
      rgb_p3_q <= rgb_p3_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  assign ch_hit      = hit_p3_q;
  assign valid_pixel = vld_p3_q;
  assign r           = rgb_p3_q[23:16];
  assign g           = rgb_p3_q[15:8];
  assign b           = rgb_p3_q[7:0];

endmodule

// File: doc/wave_display_mc.md
Name: wave_display_mc

Overview:
- Multi-channel, parametrised successor to the single-trace waveform renderer.
- Sits between the VGA/LCD timing generator (x, y, valid) and the per-channel sample RAMs; outputs pixel colour to the display mux.
- Draws up to CHANNELS traces in one window with configurable position, horizontal and vertical scaling, offset, per-channel colour and enable, line/dot mode and channel priority.
- Fully pipelined, one pixel per clock, fixed latency.

Parameters:
- CHANNELS, 2: number of traces (1..4).
- SAMPLE_W, 8: sample width in bits; also the width of the y_disp compare.
- ADDR_W, 8: log2 of samples per buffer half; read_address is ADDR_W+1 bits.
- X_START, 256: first x pixel of the window.
- X_PIX_SHIFT, 1: each sample spans 2^X_PIX_SHIFT columns.
- Y_TOP, 0: first y row of the window.
- Y_PIX_SHIFT, 1: each display row spans 2^Y_PIX_SHIFT scan rows.
- V_SHIFT, 1: sample right-shift before offset.
- Y_OFFSET, 32: added to the shifted sample.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- x  in  11  pixel column 0..1279.
- y  in  10  pixel row 0..1023.
- valid  in  1  x/y in the active area.
- read_index  in  1  buffer half select (MSB of read_address).
- read_address  out  ADDR_W+1  shared address to all channel RAMs; combinational from x, read_index.
- read_value  in  CHANNELS*SAMPLE_W  channel c data at bits [c*SAMPLE_W +: SAMPLE_W]; returned 1 clk after the address.
- mode  in  1  0 = line (vertical fill between consecutive samples), 1 = dot.
- ch_enable  in  CHANNELS  per-channel draw enable.
- ch_color  in  CHANNELS*24  per-channel {r,g,b}.
- valid_pixel  out  1  a trace pixel is lit.
- r, g, b  out  8 each  pixel colour.
- ch_hit  out  CHANNELS  per-channel lit flags, before priority resolution.

Behaviour:
- Reset: asynchronous on reset_n low. All pipeline registers, sample trackers, valid_pixel, r, g, b and ch_hit go to 0 immediately. First valid output is 3 clocks after deassertion.
- Window:
  - xo = x - X_START; in_x when 0 <= xo < 2^(ADDR_W+X_PIX_SHIFT).
  - yo = y - Y_TOP; in_y when 0 <= yo < 2^(SAMPLE_W+Y_PIX_SHIFT).
  - win = in_x && in_y && valid. Subtraction must not wrap: x < X_START means out of window.
- Address: read_address = {read_index, xo >> X_PIX_SHIFT} (low ADDR_W bits). Outside in_x the value is don't-care but must be stable (drive 0).
- Stage 1 (edge 1):
  - Register x, y-derived y_disp = yo >> Y_PIX_SHIFT (SAMPLE_W bits), win and address.
  - Per channel, register adj = (read_value >> V_SHIFT) + Y_OFFSET, saturated to 2^SAMPLE_W - 1. No wrap.
- Stage 2 (edge 2): per-channel trackers prev/curr, updated when win1 is high.
  - First win1 cycle of a row (win1 && !win1_d): prev = curr = adj. The first column has no vertical segment.
  - Otherwise, if address changed vs the previous stage-1 address: prev <= curr, curr <= adj.
  - Otherwise hold.
  - When win1 is low, clear prev and curr to 0.
- Hit per channel, registered into ch_hit at edge 3:
  - Requires win2 && ch_enable[c].
  - mode 0: min(prev,curr) <= y_disp <= max(prev,curr), inclusive.
  - mode 1: y_disp == curr.
  - mode and ch_enable are sampled at stage 2. A change mid-frame takes effect on the pixel whose stage 2 follows it.
- Priority: the lowest-index hit channel supplies ch_color to r, g, b. With no hit, r = g = b = 0 and valid_pixel = 0. valid_pixel = |ch_hit.
- Latency: x/y/valid at edge N produce r/g/b/valid_pixel/ch_hit at edge N+3. All outputs registered. Throughput is 1 pixel/clk with no stalls.
- Equal samples (prev == curr) light exactly one display row.
- A read_index change mid-row is allowed: it only alters the addresses fetched, and tracker rules are unchanged.

Test Plan:
- Reset: reset_n low mid-row with ch0 lit -> all outputs 0 within the same cycle (async). After release, first lit pixel appears exactly 3 clks after its x/y.
- Flat line: ch0 RAM all 0x40, ch1 disabled, mode 0 -> adj = 0x40. Rows y = 128,129 lit across x = 256..767 with ch0 colour. x = 255 and x = 768 are not lit. Row 127 is not lit.
- Segment: ch0 samples 0x20 then 0xA0 at addresses 0, 1 -> adj 0x30, 0x70. Column pair x = 258,259 lit for y_disp 0x30..0x70, i.e. y = 96..225. Columns 256,257 lit only at y_disp 0x30.
- Dot mode: same data, mode 1 -> x = 258,259 lit only at y_disp 0x70 (y = 224,225).
- Priority: ch0 = 0xFF0000, ch1 = 0x00FF00, both traces on the same row -> rgb = FF,00,00 and ch_hit = 2'b11. Disabling ch0 -> rgb = 00,FF,00 and ch_hit = 2'b10.
- Saturation: read_value = 0xFF, Y_OFFSET = 200 -> adj = 0xFF, no wrap; the lit row is y_disp 255 (y = 510,511).
